// File: rtl/fpu_pkg.sv
// Shared FPU constants and the binary32 field layout, used by itof, ftoi and fadd.
package fpu_pkg;

  localparam int FP_EXP_BIAS   = 127;
  localparam int FP_FRAC_W     = 23;
  localparam int FP_EXP_W      = 8;
  // Exponent of a value whose leading one sits at bit 31 of the 32-bit magnitude.
  localparam int ITOF_EXP_BASE = FP_EXP_BIAS + 31;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp32_t;

  function automatic fp32_t fp32_pack(input logic                 sign,
                                      input logic [FP_EXP_W-1:0]  exp,
                                      input logic [FP_FRAC_W-1:0] frac);
    fp32_t v;
    v.sign = sign;
    v.exp  = exp;
    v.frac = frac;
    return v;
  endfunction

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter; cnt_o = 32 and zero_o = 1 for an all-zero word.
module lzc32 (
  input  logic [31:0] data_i,
  output logic [5:0]  cnt_o,
  output logic        zero_o
);

  logic [5:0] cnt_s;

  // Scan upward so the most significant set bit writes last and wins.
  always_comb begin
    cnt_s = 6'd32;
    for (int i = 0; i < 32; i++) begin
      cnt_s = data_i[i] ? 6'(31 - i) : cnt_s;
    end
  end

  assign cnt_o  = cnt_s;
  assign zero_o = ~|data_i;

endmodule

// File: rtl/itof_pipeline.sv
// Three-stage signed int32 -> binary32 converter (RNE) with valid/ready backpressure.
// Build option: define ITOF_UNSIGNED_EN to add the is_unsigned port (fcvt.s.wu).
module itof_pipeline
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] input_a,
`ifdef ITOF_UNSIGNED_EN
  input  logic        is_unsigned,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  logic        en1_s, en2_s, en3_s;
  logic        v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic        s1_q, s1_d;
  logic [31:0] mag1_q, mag1_d;
  logic        s2_q, s2_d, z2_q, z2_d;
  logic [7:0]  exp2_q, exp2_d;
  logic [30:0] norm2_q, norm2_d;
  fp32_t       res3_q, res3_d;

  logic        sign_s;
  logic [31:0] mag_s;
  logic [5:0]  lz_s;
  logic        lz_zero_s;
  logic [30:0] norm_s;
  logic [7:0]  exp_s;
  logic        rup_s;
  logic [23:0] sum_s;
  logic [7:0]  exp_rnd_s;

  assign en3_s     = !v3_q | out_ready;
  assign en2_s     = !v2_q | en3_s;
  assign en1_s     = !v1_q | en2_s;
  assign in_ready  = en1_s;
  assign out_valid = v3_q;
  assign result    = res3_q;

  // S1: sign and magnitude; 0x80000000 negates to itself, which is right as unsigned.
  always_comb begin
`ifdef ITOF_UNSIGNED_EN
    sign_s = input_a[31] & ~is_unsigned;
`else
    sign_s = input_a[31];
`endif
    mag_s = sign_s ? (~input_a + 32'd1) : input_a;
  end

  lzc32 u_lzc (
    .data_i (mag1_q),
    .cnt_o  (lz_s),
    .zero_o (lz_zero_s)
  );

  // S2: the implied one is shifted out of the top, so only bits 30:0 are kept.
  assign norm_s = mag1_q[30:0] << lz_s;
  assign exp_s  = 8'(ITOF_EXP_BASE) - {2'b00, lz_s};

  // S3: round-to-nearest-even; a mantissa carry wraps frac to 0 and bumps the exponent.
  assign rup_s     = norm2_q[7] & ((|norm2_q[6:0]) | norm2_q[8]);
  assign sum_s     = {1'b0, norm2_q[30:8]} + {23'd0, rup_s};
  assign exp_rnd_s = exp2_q + {7'd0, sum_s[23]};

  always_comb begin
    v1_d    = v1_q;
    v2_d    = v2_q;
    v3_d    = v3_q;
    s1_d    = s1_q;
    mag1_d  = mag1_q;
    s2_d    = s2_q;
    z2_d    = z2_q;
    exp2_d  = exp2_q;
    norm2_d = norm2_q;
    res3_d  = res3_q;
    if (flush) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
      v3_d = 1'b0;
    end else begin
      if (en1_s) begin
        v1_d = in_valid;
      end else begin
        v1_d = v1_q;
      end
      if (en2_s) begin
        v2_d = v1_q;
      end else begin
        v2_d = v2_q;
      end
      if (en3_s) begin
        v3_d = v2_q;
      end else begin
        v3_d = v3_q;
      end
    end
    if (en1_s && in_valid) begin
      s1_d   = sign_s;
      mag1_d = mag_s;
    end else begin
      s1_d   = s1_q;
      mag1_d = mag1_q;
    end
    if (en2_s && v1_q) begin
      s2_d    = s1_q;
      z2_d    = lz_zero_s;
      exp2_d  = exp_s;
      norm2_d = norm_s;
    end else begin
      s2_d    = s2_q;
      z2_d    = z2_q;
      exp2_d  = exp2_q;
      norm2_d = norm2_q;
    end
    if (en3_s && v2_q) begin
      res3_d = z2_q ? fp32_t'(32'h0000_0000) : fp32_pack(s2_q, exp_rnd_s, sum_s[22:0]);
    end else begin
      res3_d = res3_q;
    end
  end

  // Pipeline state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      s1_q    <= 1'b0;
      mag1_q  <= 32'd0;
      s2_q    <= 1'b0;
      z2_q    <= 1'b0;
      exp2_q  <= 8'd0;
      norm2_q <= 31'd0;
      res3_q  <= fp32_t'(32'h0000_0000);
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      s1_q    <= s1_d;
      mag1_q  <= mag1_d;
      s2_q    <= s2_d;
      z2_q    <= z2_d;
      exp2_q  <= exp2_d;
      norm2_q <= norm2_d;
      res3_q  <= res3_d;
    end
  end

endmodule

// File: tb/tb_itof_pipeline.sv
// Self-checking bench for itof_pipeline: vector table, scoreboard, stall, flush and reset sequences.
module tb_itof_pipeline;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] input_a = 32'd0;
`ifdef ITOF_UNSIGNED_EN
  logic        is_unsigned = 1'b0;
`endif
  logic        in_ready;
  logic        out_valid;
  logic [31:0] result;

  itof_pipeline dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .input_a   (input_a),
`ifdef ITOF_UNSIGNED_EN
    .is_unsigned (is_unsigned),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp;
    int          acc;
  } sb_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] exp;
  } vec_t;

  sb_t         sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          popped = 0;
  bit          chk_lat = 1'b0;
  logic [31:0] cur_exp = 32'd0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, got, want);
    end
  endtask

  // Independent reference: locate the MSB, truncate, then round by comparing the remainder to half.
  function automatic logic [31:0] ref_itof(input logic [31:0] a);
    logic           s;
    longint unsigned m, mant, rem, half;
    int             msb, sh, e;
    if (a == 32'd0) return 32'h0;
    s = a[31];
    m = s ? (64'h1_0000_0000 - {32'h0, a}) : {32'h0, a};
    msb = 0;
    for (int i = 0; i < 33; i++) if (m[i]) msb = i;
    e = 127 + msb;
    if (msb <= 23) begin
      mant = m << (23 - msb);
    end else begin
      sh   = msb - 23;
      mant = m >> sh;
      rem  = m & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && mant[0])) mant++;
      if (mant == (64'd1 << 24)) begin
        mant = 64'd1 << 23;
        e++;
      end
    end
    return {s, 8'(e), mant[22:0]};
  endfunction

  // One clock: evaluate both handshakes mid-cycle, update scoreboard, advance to next negedge.
  task automatic step(output bit acc);
    sb_t e;
    #1;
    acc = in_valid && in_ready && !flush;
    if (!flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got %08h expected none", result);
      end else begin
        e = sb.pop_front();
        popped++;
        check("result", result, e.exp);
        if (chk_lat) check("latency", 32'(cyc - e.acc), 32'd3);
      end
    end
    if (flush) sb.delete();
    else if (acc) sb.push_back('{cur_exp, cyc});
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    bit acc;
    in_valid = 1'b0;
    for (int n = 0; n < budget && sb.size() > 0; n++) step(acc);
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        vt[13];
    logic [31:0] ops[8];
    bit          acc, hold, saw_low;
    logic [31:0] hv;
    int          i, p0;

    vt[0]  = '{32'd1,        32'h3F80_0000};
    vt[1]  = '{32'hFFFF_FFFF, 32'hBF80_0000};
    vt[2]  = '{32'd0,        32'h0000_0000};
    vt[3]  = '{32'h7FFF_FFFF, 32'h4F00_0000};
    vt[4]  = '{32'h8000_0000, 32'hCF00_0000};
    vt[5]  = '{32'd16777217, 32'h4B80_0000};
    vt[6]  = '{32'd16777219, 32'h4B80_0002};
    vt[7]  = '{32'd16777221, 32'h4B80_0002};
    vt[8]  = '{32'd5,        32'h40A0_0000};
    vt[9]  = '{32'd3,        32'h4040_0000};
    vt[10] = '{32'hFFFF_FFF9, 32'hC0E0_0000};
    vt[11] = '{32'h00FF_FFFF, 32'h4B7F_FFFF};
    vt[12] = '{32'h01FF_FFFF, 32'h4C00_0000};

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", result, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // Table stream, back-to-back, out_ready high: each result 3 cycles after accept.
    chk_lat   = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 13; k++) begin
      in_valid = 1'b1;
      input_a  = vt[k].a;
      cur_exp  = vt[k].exp;
      step(acc);
      check("table_accept", 32'(acc), 32'd1);
    end
    drain(10);
    chk_lat = 1'b0;

    // Eight-operand stream with out_ready low for stream cycles 4-7.
    for (int k = 0; k < 8; k++) begin
      ops[k] = $urandom() >> $urandom_range(0, 28);
      if (k[0]) ops[k] = ~ops[k] + 32'd1;
    end
    i = 0; hold = 1'b0; saw_low = 1'b0; hv = 32'd0; p0 = popped;
    for (int c = 0; c < 60 && (popped - p0) < 8; c++) begin
      out_ready = !(c >= 4 && c <= 7);
      if (i < 8) begin
        in_valid = 1'b1;
        input_a  = ops[i];
        cur_exp  = ref_itof(ops[i]);
      end else begin
        in_valid = 1'b0;
      end
      if (hold) check("stall_hold", result, hv);
      hold = out_valid && !out_ready;
      hv   = result;
      step(acc);
      if (acc) i++;
      else if (in_valid) saw_low = 1'b1;
    end
    in_valid = 1'b0;
    check("stall_in_ready_fell", 32'(saw_low), 32'd1);
    check("stall_count", 32'(popped - p0), 32'd8);
    check("stall_sb_empty", 32'(sb.size()), 32'd0);

    // Flush with three in flight and a fourth offered.
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      input_a  = 32'(11 + k);
      cur_exp  = ref_itof(32'(11 + k));
      step(acc);
    end
    check("flush_pre_valid", 32'(out_valid), 32'd1);
    input_a = 32'd99;
    cur_exp = ref_itof(32'd99);
    flush   = 1'b1;
    step(acc);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    chk_lat  = 1'b1;
    in_valid = 1'b1;
    input_a  = 32'd5;
    cur_exp  = 32'h40A0_0000;
    step(acc);
    check("flush_next_accept", 32'(acc), 32'd1);
    drain(8);
    chk_lat = 1'b0;

    // Asynchronous reset mid-stream.
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      input_a  = 32'(100 + k);
      cur_exp  = ref_itof(32'(100 + k));
      step(acc);
    end
    in_valid = 1'b0;
    check("rst_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(out_valid), 32'd0);
    check("rst_async_result", result, 32'h0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_post_valid", 32'(out_valid), 32'd0);

`ifdef ITOF_UNSIGNED_EN
    chk_lat     = 1'b1;
    is_unsigned = 1'b1;
    in_valid    = 1'b1;
    input_a     = 32'hFFFF_FFFF;
    cur_exp     = 32'h4F80_0000;
    step(acc);
    input_a     = 32'h8000_0000;
    cur_exp     = 32'h4F00_0000;
    step(acc);
    is_unsigned = 1'b0;
    drain(8);
    chk_lat     = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
